// File: rtl/strip_release_unit_if.sv
// rtl/strip_release_unit_if.sv - Commit, release and min-result signal bundle for strip_release_unit
interface strip_release_unit_if #(
  parameter int NUM_STRIPS = 8
);
  localparam int IDX_W = $clog2(NUM_STRIPS);

  logic             alloc_we;
  logic [IDX_W-1:0] alloc_idx;
  logic [7:0]       alloc_width;
  logic             rel_valid;
  logic             rel_ready;
  logic [IDX_W-1:0] rel_idx;
  logic [4:0]       rel_width;
  logic [7:0]       min_occupied_strip_width;
  logic [IDX_W-1:0] min_strip_idx;
  logic             done;
  logic             underflow_flag;

  modport master (
    output alloc_we, alloc_idx, alloc_width, rel_valid, rel_idx, rel_width,
    input  rel_ready, min_occupied_strip_width, min_strip_idx, done, underflow_flag
  );

  modport slave (
    input  alloc_we, alloc_idx, alloc_width, rel_valid, rel_idx, rel_width,
    output rel_ready, min_occupied_strip_width, min_strip_idx, done, underflow_flag
  );
endinterface

// File: rtl/strip_release_unit.sv
// rtl/strip_release_unit.sv - Strip occupancy table with commit/release updates and serial min scan
// Optional RELEASE_CLAMP_EN: an underflowing release zeroes the strip instead of leaving it unchanged.
module strip_release_unit #(
  parameter int NUM_STRIPS = 8,
  parameter int STRIP_CAP  = 128
) (
  input logic                clk,
  input logic                rst_n,
  strip_release_unit_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_STRIPS);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_UPDATE = 2'd1;
  localparam logic [1:0] S_SCAN   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [7:0]       CAP_W    = 8'(STRIP_CAP);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STRIPS - 1);

  logic [1:0]       state;
  logic [7:0]       tbl [NUM_STRIPS];
  logic [IDX_W-1:0] rel_idx_q;
  logic [4:0]       rel_width_q;
  logic [IDX_W-1:0] scan_idx;
  logic [7:0]       run_min;
  logic [IDX_W-1:0] run_idx;
  logic             underflow_q;
  logic [7:0]       min_q;
  logic [IDX_W-1:0] min_idx_q;

  logic             accept_alloc;
  logic             accept_rel;
  logic [7:0]       alloc_clamped;
  logic [7:0]       tgt_width;
  logic [7:0]       rel_width_ext;
  logic             rel_under;
  logic [7:0]       cur_width;
  logic [7:0]       scan_min;
  logic [IDX_W-1:0] scan_min_idx;

  assign bus.rel_ready = (state == S_IDLE) && !bus.alloc_we;
  assign accept_alloc  = (state == S_IDLE) && bus.alloc_we;
  assign accept_rel    = bus.rel_valid && bus.rel_ready;

  assign bus.done                     = (state == S_DONE);
  assign bus.underflow_flag           = (state == S_DONE) && underflow_q;
  assign bus.min_occupied_strip_width = min_q;
  assign bus.min_strip_idx            = min_idx_q;

  always_comb begin
    alloc_clamped = (bus.alloc_width > CAP_W) ? CAP_W : bus.alloc_width;
    tgt_width     = tbl[rel_idx_q];
    rel_width_ext = {3'b000, rel_width_q};
    rel_under     = rel_width_ext > tgt_width;
    cur_width     = tbl[scan_idx];
    scan_min      = run_min;
    scan_min_idx  = run_idx;
    // Strip 0 seeds the running min; strict less-than keeps the lowest index on ties.
    if (scan_idx == '0 || cur_width < run_min) begin
      scan_min     = cur_width;
      scan_min_idx = scan_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      for (int i = 0; i < NUM_STRIPS; i++) tbl[i] <= '0;
      rel_idx_q   <= '0;
      rel_width_q <= '0;
      scan_idx    <= '0;
      run_min     <= '0;
      run_idx     <= '0;
      underflow_q <= 1'b0;
      min_q       <= '0;
      min_idx_q   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept_alloc) begin
            tbl[bus.alloc_idx] <= alloc_clamped;
            underflow_q        <= 1'b0;
            scan_idx           <= '0;
            state              <= S_SCAN;
          end else if (accept_rel) begin
            rel_idx_q   <= bus.rel_idx;
            rel_width_q <= bus.rel_width;
            state       <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          underflow_q <= rel_under;
          if (!rel_under) begin
            tbl[rel_idx_q] <= tgt_width - rel_width_ext;
          end
`ifdef RELEASE_CLAMP_EN
          else begin
            tbl[rel_idx_q] <= '0;
          end
`endif
          scan_idx <= '0;
          state    <= S_SCAN;
        end
        S_SCAN: begin
          run_min  <= scan_min;
          run_idx  <= scan_min_idx;
          scan_idx <= scan_idx + 1'b1;
          if (scan_idx == LAST_IDX) begin
            min_q     <= scan_min;
            min_idx_q <= scan_min_idx;
            state     <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_strip_release_unit.sv
// tb/tb_strip_release_unit.sv - Directed bench for strip_release_unit with an occupancy-table reference model
module tb_strip_release_unit;
  localparam int NS  = 8;
  localparam int CAP = 128;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  strip_release_unit_if #(.NUM_STRIPS(NS)) bus ();

  strip_release_unit #(.NUM_STRIPS(NS), .STRIP_CAP(CAP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: an occupancy array plus the edge on which the result must appear.
  int m_tbl [NS];
  bit busy      = 1'b0;
  int cyc       = 0;
  int done_edge = -10;
  int pend_min  = 0;
  int pend_idx  = 0;
  bit pend_uf   = 1'b0;
  int out_min   = 0;
  int out_idx   = 0;

  function automatic void model_scan();
    pend_min = m_tbl[0];
    pend_idx = 0;
    for (int i = 1; i < NS; i++) begin
      if (m_tbl[i] < pend_min) begin
        pend_min = m_tbl[i];
        pend_idx = i;
      end
    end
  endfunction

  initial begin
    for (int i = 0; i < NS; i++) m_tbl[i] = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int i = 0; i < NS; i++) m_tbl[i] = 0;
        busy      = 1'b0;
        pend_uf   = 1'b0;
        out_min   = 0;
        out_idx   = 0;
        done_edge = -10;
      end else begin
        cyc++;
        if (busy) begin
          if (cyc == done_edge) begin
            out_min = pend_min;
            out_idx = pend_idx;
          end else if (cyc == done_edge + 1) begin
            busy = 1'b0;
          end
        end else if (bus.alloc_we) begin
          m_tbl[bus.alloc_idx] = (int'(bus.alloc_width) > CAP) ? CAP : int'(bus.alloc_width);
          pend_uf   = 1'b0;
          done_edge = cyc + NS;
          busy      = 1'b1;
          model_scan();
        end else if (bus.rel_valid) begin
          if (int'(bus.rel_width) > m_tbl[bus.rel_idx]) begin
            pend_uf = 1'b1;
`ifdef RELEASE_CLAMP_EN
            m_tbl[bus.rel_idx] = 0;
`endif
          end else begin
            pend_uf = 1'b0;
            m_tbl[bus.rel_idx] = m_tbl[bus.rel_idx] - int'(bus.rel_width);
          end
          done_edge = cyc + NS + 1;
          busy      = 1'b1;
          model_scan();
        end
      end
    end
  end

  initial begin
    logic exp_done;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_underflow", 32'(bus.underflow_flag), 32'd0);
        chk("rst_min", 32'(bus.min_occupied_strip_width), 32'd0);
        chk("rst_min_idx", 32'(bus.min_strip_idx), 32'd0);
      end else begin
        exp_done = busy && (cyc == done_edge);
        chk("done", 32'(bus.done), 32'(exp_done));
        chk("rel_ready", 32'(bus.rel_ready), 32'(!busy && !bus.alloc_we));
        chk("min", 32'(bus.min_occupied_strip_width), out_min);
        chk("min_idx", 32'(bus.min_strip_idx), out_idx);
        chk("underflow", 32'(bus.underflow_flag), 32'(exp_done && pend_uf));
      end
    end
  end

  task automatic wait_done(input string name, input int exp_lat);
    int lat = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        lat = k;
        break;
      end
    end
    chk({name, "_latency"}, lat, exp_lat);
  endtask

  task automatic do_alloc(input logic [2:0] idx, input logic [7:0] w);
    @(posedge clk); #1;
    bus.alloc_we    = 1'b1;
    bus.alloc_idx   = idx;
    bus.alloc_width = w;
    @(posedge clk); #1;
    bus.alloc_we = 1'b0;
    wait_done("alloc", NS + 1);
  endtask

  task automatic accept_rel();
    bit ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (bus.rel_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("rel_accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.rel_valid = 1'b0;
  endtask

  task automatic do_rel(input logic [2:0] idx, input logic [4:0] w);
    @(posedge clk); #1;
    bus.rel_valid = 1'b1;
    bus.rel_idx   = idx;
    bus.rel_width = w;
    accept_rel();
    wait_done("release", NS + 2);
  endtask

  task automatic chk_result(input string name, input int mn, input int ix, input int uf);
    chk({name, "_min"}, 32'(bus.min_occupied_strip_width), mn);
    chk({name, "_idx"}, 32'(bus.min_strip_idx), ix);
    chk({name, "_uf"}, 32'(bus.underflow_flag), uf);
  endtask

  initial begin
    bus.alloc_we    = 1'b0;
    bus.alloc_idx   = '0;
    bus.alloc_width = '0;
    bus.rel_valid   = 1'b0;
    bus.rel_idx     = '0;
    bus.rel_width   = '0;

    repeat (3) @(posedge clk);
    @(negedge clk); #2;
    rst_n = 1'b1;
    #1 chk("ready_after_reset", 32'(bus.rel_ready), 32'd1);

    // Zero-width release on a fresh table
    do_rel(3'd0, 5'd0);
    chk_result("rel_zero", 0, 0, 0);

    // Commit a table and check the min search and the capacity clamp
    do_alloc(3'd0, 8'd100);
    do_alloc(3'd1, 8'd60);
    for (int i = 2; i < NS; i++) do_alloc(3'(i), 8'd128);
    chk_result("alloc_fill", 60, 1, 0);
    do_alloc(3'd3, 8'd200);
    chk_result("alloc_clamp", 60, 1, 0);

    do_rel(3'd0, 5'd31);
    chk_result("rel_0_a", 60, 1, 0);
    do_rel(3'd0, 5'd31);
    chk_result("rel_0_b", 38, 0, 0);
    do_alloc(3'd4, 8'd38);
    chk_result("tie_low_idx", 38, 0, 0);
    // Strip 3 holds the clamped 128, so three 31-wide releases leave 35
    do_rel(3'd3, 5'd31);
    do_rel(3'd3, 5'd31);
    chk_result("rel_3_b", 38, 0, 0);
    do_rel(3'd3, 5'd31);
    chk_result("rel_3_c", 35, 3, 0);

    // Commit and release presented together: commit wins, release follows
    @(posedge clk); #1;
    bus.alloc_we    = 1'b1;
    bus.alloc_idx   = 3'd5;
    bus.alloc_width = 8'd20;
    bus.rel_valid   = 1'b1;
    bus.rel_idx     = 3'd2;
    bus.rel_width   = 5'd5;
    @(negedge clk);
    chk("collide_ready", 32'(bus.rel_ready), 32'd0);
    @(posedge clk); #1;
    bus.alloc_we = 1'b0;
    wait_done("collide_alloc", NS + 1);
    chk_result("collide_alloc", 20, 5, 0);
    accept_rel();
    wait_done("collide_rel", NS + 2);
    chk_result("collide_rel", 20, 5, 0);

    // Reset in the middle of the scan abandons the release
    @(posedge clk); #1;
    bus.rel_valid = 1'b1;
    bus.rel_idx   = 3'd0;
    bus.rel_width = 5'd1;
    accept_rel();
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_result("mid_scan_rst", 0, 0, 0);
    chk("mid_scan_rst_done", 32'(bus.done), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk); #2;
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("no_done_after_rst", 32'(bus.done), 32'd0);
    end
    for (int i = 0; i < NS; i++) begin
      do_rel(3'(i), 5'd1);
      chk_result("table_cleared", 0, 0, 1);
    end

    // Underflowing release
    for (int i = 0; i < NS; i++) do_alloc(3'(i), 8'd50);
    do_alloc(3'd1, 8'd10);
    chk_result("uf_setup", 10, 1, 0);
    do_rel(3'd1, 5'd20);
`ifdef RELEASE_CLAMP_EN
    chk_result("uf_release", 0, 1, 1);
`else
    chk_result("uf_release", 10, 1, 1);
`endif
    do_rel(3'd1, 5'd0);
`ifdef RELEASE_CLAMP_EN
    chk_result("uf_followup", 0, 1, 0);
`else
    chk_result("uf_followup", 10, 1, 0);
`endif

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/strip_release_unit.md
STRIP_RELEASE_UNIT -- requirements
Module: strip_release_unit

Interface
REQ-001 Parameter NUM_STRIPS, default 8, number of placement strips tracked (power of two, 2..16).
REQ-002 Parameter STRIP_CAP, default 128, strip width capacity in columns.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 alloc_we  input  1  placement commit strobe, writes a strip occupancy.
REQ-006 alloc_idx  input  log2(NUM_STRIPS)  strip index for commit.
REQ-007 alloc_width  input  8  new occupied width for commit.
REQ-008 rel_valid  input  1  release request valid (program leaving a strip).
REQ-009 rel_ready  output  1  release request accept.
REQ-010 rel_idx  input  log2(NUM_STRIPS)  strip index to release from.
REQ-011 rel_width  input  5  program width to free.
REQ-012 min_occupied_strip_width  output  8  occupancy of least-occupied strip.
REQ-013 min_strip_idx  output  log2(NUM_STRIPS)  index of least-occupied strip.
REQ-014 done  output  1  one-cycle pulse: table update and min scan complete.
REQ-015 underflow_flag  output  1  one-cycle pulse with done: release exceeded occupancy.

Function
REQ-016 FSM states SHALL be IDLE, UPDATE, SCAN, DONE; DONE always returns to IDLE.
REQ-017 rel_ready SHALL be combinational: high only when state==IDLE and alloc_we==0.
REQ-018 Release handshake = rel_valid & rel_ready at edge T; rel_idx/rel_width SHALL be captured at T; state -> UPDATE.
REQ-019 UPDATE (T+1) SHALL write table[rel_idx] = table[rel_idx] - rel_width (zero-extended to 8 bits); state -> SCAN.
REQ-020 alloc_we in IDLE SHALL write table[alloc_idx] = min(alloc_width, STRIP_CAP) at that edge; state -> SCAN directly; alloc_we outside IDLE SHALL be ignored.
REQ-021 SCAN SHALL examine one strip per cycle, index 0..NUM_STRIPS-1, tracking running min; strict less-than compare, so ties resolve to lowest index.
REQ-022 After the last strip, state -> DONE; at entry to DONE, min_occupied_strip_width and min_strip_idx SHALL register the scan result and hold until the next DONE.
REQ-023 done SHALL be high exactly in the DONE cycle; release latency handshake-to-done = NUM_STRIPS+2 cycles (10 at default); alloc latency = NUM_STRIPS+1.
REQ-024 underflow_flag SHALL assert in DONE only for a release where rel_width > table[rel_idx] before update; low otherwise.
REQ-025 rel_valid held high while rel_ready low SHALL not be accepted; no request queuing.
REQ-026 Release of width 0 SHALL be legal: table unchanged, full scan, done pulses.

Reset
REQ-027 rst_n low SHALL immediately force: state IDLE, all table entries 0, min_occupied_strip_width 0, min_strip_idx 0, done 0, underflow_flag 0, captured request cleared.
REQ-028 Reset asserted mid-UPDATE/SCAN SHALL abandon the operation; no done pulse follows deassertion.
REQ-029 First edge after rst_n deassertion SHALL see rel_ready high (if alloc_we low).

Configuration
REQ-030 Macro RELEASE_CLAMP_EN defined: underflowing release SHALL write 0 to table[rel_idx] and pulse underflow_flag.
REQ-031 RELEASE_CLAMP_EN undefined: underflowing release SHALL leave table[rel_idx] unchanged (write suppressed), still pulse underflow_flag, still scan.

Verification
REQ-032 Reset, then rel_valid=1 idx 0 width 0 -> rel_ready=1, done at +10 cycles, min=0, idx=0, underflow 0.
REQ-033 alloc writes 0:100, 1:60, 2..7:128 -> after last alloc done, min=60, min_strip_idx=1; alloc_width 200 to strip 3 stores 128.
REQ-034 From REQ-033 state, release idx 0 width 31, then idx 0 width 31 -> min=38, idx=0; ties test: set strip 4 = 38 -> idx stays 0.
REQ-035 Strip 1=10, release idx 1 width 20 -> underflow_flag=1 with done; clamp build table[1]=0, min=0; non-clamp build table[1]=10.
REQ-036 alloc_we and rel_valid high same IDLE cycle -> rel_ready=0, alloc written, release accepted after following DONE.
REQ-037 rst_n low during SCAN cycle 4 -> outputs 0 immediately, no done after release, table all 0.
